// File: rtl/oled_spi_tx_if.sv
// ============================================================================
//  Module      : oled_spi_tx_if
//  Description : Write-side valid/ready bundle for the OLED SPI transmitter.
//                Carries one {LAST, DC, DATA} word per accepted transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oled_spi_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_dc;
    logic              wr_last;
    logic              wr_valid;
    logic              wr_ready;

    // Producer side
    modport master (
        output wr_data,
        output wr_dc,
        output wr_last,
        output wr_valid,
        input  wr_ready
    );

    // Transmitter side
    modport slave (
        input  wr_data,
        input  wr_dc,
        input  wr_last,
        input  wr_valid,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/oled_spi_tx.sv
// ============================================================================
//  Module      : oled_spi_tx
//  Description : SPI write master for the OLED panel. Words enter a small FIFO
//                and are shifted MSB-first; CS stays low across consecutive
//                words until a word tagged LAST has been sent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_spi_tx #(
    parameter int DATA_W     = 8,
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0
) (
    input  wire logic                        clk_i,
    input  wire logic                        rst_i,
    oled_spi_tx_if.slave                     wr_if,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             frame_done_o,
    output logic                             sclk_o,
    output logic                             cs_o,
    output logic                             dc_o,
    output logic                             din_o
);

    localparam int   AW       = $clog2(FIFO_DEPTH);
    localparam int   CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   BIT_W    = $clog2(DATA_W);
    localparam int   ENTRY_W  = DATA_W + 2;
    localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_STALL = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Word FIFO: entry = {last, dc, data}
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic               w_ready, w_push, w_pop, w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_ready        = (level_q != (AW+1)'(FIFO_DEPTH));
    assign w_push         = wr_if.wr_valid && w_ready;
    assign w_empty        = (level_q == '0);
    assign w_head         = mem_q[rd_ptr_q];
    assign wr_if.wr_ready = w_ready;
    assign fifo_level_o   = level_q;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {wr_if.wr_last, wr_if.wr_dc, wr_if.wr_data};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap on power-of-2 depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic                dc_q, dc_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                done_q, done_d;
    logic                fdone_q, fdone_d;
    logic                w_tick;

    assign w_tick = (cnt_q == CNT_W'(DIV - 1));

    // State and registered pin drivers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            dc_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= IDLE_LVL;
            done_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            dc_q    <= dc_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
            fdone_q <= fdone_d;
        end
    end

    // Next-state logic; pin levels are derived from the next state so the
    // registered outputs change on the same edge the state does.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        w_pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_tick) begin
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        bit_d   = bit_q - 1'b1;
                        state_d = S_LOW;
                    end else begin
                        done_d = 1'b1;
                        if (last_q) begin
                            state_d = S_HOLD;
                        end else if (!w_empty) begin
                            // Chain straight into the next word on this falling edge.
                            w_pop   = 1'b1;
                            state_d = S_LOW;
                        end else begin
                            state_d = S_STALL;
                        end
                    end
                end
            end
            S_STALL: begin
                cnt_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_LOW;
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Loading a word from the FIFO head.
        if (w_pop) begin
            shift_d = w_head[DATA_W-1:0];
            dc_d    = w_head[DATA_W];
            last_d  = w_head[DATA_W+1];
            bit_d   = BIT_W'(DATA_W - 1);
        end

        fdone_d = (state_d == S_GAP) && (state_q != S_GAP);

        cs_d   = 1'b1;
        sclk_d = IDLE_LVL;
        case (state_d)
            S_SETUP, S_HOLD: cs_d = 1'b0;
            S_LOW: begin
                cs_d   = 1'b0;
                sclk_d = 1'b0;
            end
            S_HIGH, S_STALL: begin
                cs_d   = 1'b0;
                sclk_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign sclk_o       = sclk_q;
    assign cs_o         = cs_q;
    assign dc_o         = dc_q;
    assign din_o        = shift_q[DATA_W-1];
    assign done_o       = done_q;
    assign frame_done_o = fdone_q;
    assign busy_o       = (state_q != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_tx.sv
// ============================================================================
//  Module      : tb_oled_spi_tx
//  Description : Directed self-checking bench for oled_spi_tx. Instance 0 is
//                DIV=2/CPOL=0, instance 1 is DIV=1/CPOL=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    oled_spi_tx_if #(.DATA_W(8)) if0 ();
    oled_spi_tx_if #(.DATA_W(8)) if1 ();

    logic [2:0] s_level0, s_level1;
    logic s_busy0, s_done0, s_fd0, s_sclk0, s_cs0, s_dc0, s_din0;
    logic s_busy1, s_done1, s_fd1, s_sclk1, s_cs1, s_dc1, s_din1;

    oled_spi_tx #(.DATA_W(8), .DIV(2), .FIFO_DEPTH(4), .CPOL(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .wr_if(if0),
        .fifo_level_o(s_level0), .busy_o(s_busy0), .done_o(s_done0),
        .frame_done_o(s_fd0), .sclk_o(s_sclk0), .cs_o(s_cs0),
        .dc_o(s_dc0), .din_o(s_din0)
    );

    oled_spi_tx #(.DATA_W(8), .DIV(1), .FIFO_DEPTH(4), .CPOL(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .wr_if(if1),
        .fifo_level_o(s_level1), .busy_o(s_busy1), .done_o(s_done1),
        .frame_done_o(s_fd1), .sclk_o(s_sclk1), .cs_o(s_cs1),
        .dc_o(s_dc1), .din_o(s_din1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Bus observers (cumulative; checks work on differences)
    logic bits0 [0:511];
    logic dcs0  [0:511];
    int rises0 = 0, dones0 = 0, fds0 = 0, frames0 = 0, run0 = 0, last_run0 = 0;
    int t_done0 = 0, t_fd0 = 0;
    logic psclk0 = 1'b0, pcs0 = 1'b1;

    logic bits1 [0:511];
    int rises1 = 0, fds1 = 0, run1 = 0, last_run1 = 0;
    logic psclk1 = 1'b1, pcs1 = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (s_sclk0 && !psclk0) begin
            bits0[rises0] = s_din0;
            dcs0[rises0]  = s_dc0;
            rises0++;
        end
        if (s_done0) begin dones0++; t_done0 = cyc; end
        if (s_fd0)   begin fds0++;   t_fd0   = cyc; end
        if (!s_cs0) begin
            if (pcs0) begin frames0++; run0 = 0; end
            run0++;
        end else if (!pcs0) begin
            last_run0 = run0;
        end
        psclk0 = s_sclk0;
        pcs0   = s_cs0;

        if (s_sclk1 && !psclk1) begin
            bits1[rises1] = s_din1;
            rises1++;
        end
        if (s_fd1) fds1++;
        if (!s_cs1) begin
            if (pcs1) run1 = 0;
            run1++;
        end else if (!pcs1) begin
            last_run1 = run1;
        end
        psclk1 = s_sclk1;
        pcs1   = s_cs1;
    end

    function automatic logic [7:0] byte0(input int base);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits0[base+i]};
        return b;
    endfunction

    function automatic logic [7:0] dcbyte0(input int base);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], dcs0[base+i]};
        return b;
    endfunction

    function automatic logic [7:0] byte1(input int base);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits1[base+i]};
        return b;
    endfunction

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with valid low.
    task automatic push0(input logic [7:0] d, input logic dc, input logic last);
        int k = 0;
        if0.wr_data  = d;
        if0.wr_dc    = dc;
        if0.wr_last  = last;
        if0.wr_valid = 1'b1;
        while (!if0.wr_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_b("push0_ready", if0.wr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if0.wr_valid = 1'b0;
    endtask

    task automatic push1(input logic [7:0] d, input logic dc, input logic last);
        int k = 0;
        if1.wr_data  = d;
        if1.wr_dc    = dc;
        if1.wr_last  = last;
        if1.wr_valid = 1'b1;
        while (!if1.wr_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_b("push1_ready", if1.wr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if1.wr_valid = 1'b0;
    endtask

    task automatic wait_fd0(input string tag, input int target);
        int k = 0;
        while (fds0 < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_i(tag, fds0, target);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, dn, f, fr;
        logic [7:0] words [6];
        words[0] = 8'h10; words[1] = 8'h2B; words[2] = 8'h3C;
        words[3] = 8'h4D; words[4] = 8'h5E; words[5] = 8'h6F;

        if0.wr_data = 8'h00; if0.wr_dc = 1'b0; if0.wr_last = 1'b0; if0.wr_valid = 1'b0;
        if1.wr_data = 8'h00; if1.wr_dc = 1'b0; if1.wr_last = 1'b0; if1.wr_valid = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_b("rst_cs0",    s_cs0,    1'b1);
        check_b("rst_sclk0",  s_sclk0,  1'b0);
        check_b("rst_din0",   s_din0,   1'b0);
        check_b("rst_dc0",    s_dc0,    1'b0);
        check_b("rst_done0",  s_done0,  1'b0);
        check_b("rst_fd0",    s_fd0,    1'b0);
        check_i("rst_level0", int'(s_level0), 0);
        check_b("rst_ready0", if0.wr_ready, 1'b1);
        check_b("rst_busy0",  s_busy0,  1'b0);
        check_b("rst_sclk1",  s_sclk1,  1'b1);
        check_b("rst_cs1",    s_cs1,    1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word 0xA5, DC=1, LAST
        r = rises0; dn = dones0; f = fds0; fr = frames0;
        push0(8'hA5, 1'b1, 1'b1);
        wait_fd0("t1_frame_done", f + 1);
        check_i("t1_rises",   rises0 - r, 8);
        check_8("t1_din",     byte0(r),   8'hA5);
        check_8("t1_dc",      dcbyte0(r), 8'hFF);
        check_i("t1_dones",   dones0 - dn, 1);
        check_i("t1_frames",  frames0 - fr, 1);
        check_i("t1_cs_low",  last_run0, 36);
        check_b("t1_order",   t_done0 < t_fd0, 1'b1);
        check_b("t1_sclk_end", s_sclk0, 1'b0);
        check_b("t1_cs_end",  s_cs0, 1'b1);
        check_b("t1_busy_end", s_busy0, 1'b0);

        // Three-word burst, one frame
        r = rises0; dn = dones0; f = fds0; fr = frames0;
        push0(8'h11, 1'b0, 1'b0);
        push0(8'h22, 1'b1, 1'b0);
        push0(8'h33, 1'b1, 1'b1);
        wait_fd0("t2_frame_done", f + 1);
        check_i("t2_rises",  rises0 - r, 24);
        check_8("t2_w0",     byte0(r),      8'h11);
        check_8("t2_w1",     byte0(r + 8),  8'h22);
        check_8("t2_w2",     byte0(r + 16), 8'h33);
        check_8("t2_dc0",    dcbyte0(r),      8'h00);
        check_8("t2_dc1",    dcbyte0(r + 8),  8'hFF);
        check_8("t2_dc2",    dcbyte0(r + 16), 8'hFF);
        check_i("t2_dones",  dones0 - dn, 3);
        check_i("t2_frames", frames0 - fr, 1);
        check_i("t2_cs_low", last_run0, 100);

        // Underrun mid-frame: STALL with SCLK high
        r = rises0; dn = dones0; f = fds0; fr = frames0;
        push0(8'h81, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check_b("t3_stall_sclk", s_sclk0, 1'b1);
        check_b("t3_stall_cs",   s_cs0,   1'b0);
        check_b("t3_stall_busy", s_busy0, 1'b1);
        check_i("t3_stall_done", dones0 - dn, 1);
        check_i("t3_stall_fd",   fds0 - f, 0);
        push0(8'h7E, 1'b1, 1'b1);
        wait_fd0("t3_frame_done", f + 1);
        check_i("t3_rises",  rises0 - r, 16);
        check_8("t3_w0",     byte0(r),     8'h81);
        check_8("t3_w1",     byte0(r + 8), 8'h7E);
        check_i("t3_dones",  dones0 - dn, 2);
        check_i("t3_frames", frames0 - fr, 1);

        // FIFO fill with back-pressure
        r = rises0; dn = dones0; f = fds0; fr = frames0;
        for (int k = 0; k < 5; k++) push0(words[k], 1'b1, 1'b0);
        check_i("t4_level_full", int'(s_level0), 4);
        check_b("t4_ready_low",  if0.wr_ready, 1'b0);
        push0(words[5], 1'b1, 1'b1);
        check_i("t4_level_refill", int'(s_level0), 4);
        wait_fd0("t4_frame_done", f + 1);
        check_i("t4_rises", rises0 - r, 48);
        for (int k = 0; k < 6; k++)
            check_8($sformatf("t4_w%0d", k), byte0(r + 8*k), words[k]);
        check_i("t4_dones",  dones0 - dn, 6);
        check_i("t4_frames", frames0 - fr, 1);
        check_i("t4_cs_low", last_run0, 196);

        // CPOL=1, DIV=1 instance
        r = rises1; f = fds1;
        check_b("t5_idle_sclk", s_sclk1, 1'b1);
        push1(8'hC3, 1'b1, 1'b1);
        begin
            int k = 0;
            while (fds1 < f + 1 && k < 1000) begin
                @(negedge clk);
                k++;
            end
        end
        check_i("t5_frame_done", fds1, f + 1);
        repeat (3) @(negedge clk);
        check_i("t5_rises",   rises1 - r, 8);
        check_8("t5_din",     byte1(r), 8'hC3);
        check_i("t5_cs_low",  last_run1, 18);
        check_b("t5_sclk_end", s_sclk1, 1'b1);
        check_b("t5_cs_end",  s_cs1, 1'b1);

        // Reset during the 4th bit with two words queued
        r = rises0;
        push0(8'h96, 1'b0, 1'b0);
        push0(8'hAA, 1'b1, 1'b0);
        push0(8'h55, 1'b1, 1'b1);
        check_i("t6_queued", int'(s_level0), 2);
        begin
            int k = 0;
            while (rises0 - r < 4 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check_i("t6_reached_bit4", rises0 - r, 4);
        rst = 1'b1;
        #1;
        check_b("t6_cs",    s_cs0,   1'b1);
        check_b("t6_sclk",  s_sclk0, 1'b0);
        check_i("t6_level", int'(s_level0), 0);
        check_b("t6_ready", if0.wr_ready, 1'b1);
        check_b("t6_busy",  s_busy0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        r = rises0; dn = dones0; f = fds0;
        push0(8'hFF, 1'b1, 1'b1);
        wait_fd0("t6_frame_done", f + 1);
        check_i("t6_rises",  rises0 - r, 8);
        check_8("t6_din",    byte0(r), 8'hFF);
        check_i("t6_dones",  dones0 - dn, 1);
        check_i("t6_cs_low", last_run0, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
